// File: rtl/twofish_pkg.sv
// Shared Twofish constants, types and GF(2^8) helper for the key-schedule blocks.
// Build option: define TWOFISH_KEY256_EN for 256-bit keys (four S-words instead of two).
package twofish_pkg;

   typedef logic [7:0] byte_t;

   localparam logic [8:0] RS_POLY  = 9'h14D;
   localparam logic [8:0] MDS_POLY = 9'h169;

   // RS generator g(x) = x^4 + A4 x^3 + 02 x^2 + A4 x + 01; byte k holds the x^k coefficient
   localparam logic [31:0] RS_GEN = 32'hA402A401;

`ifdef TWOFISH_KEY256_EN
   localparam int KEY_W = 256;
`else
   localparam int KEY_W = 128;
`endif
   localparam int NUM_WORDS = KEY_W / 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   function automatic byte_t gf_mul(input byte_t a, input byte_t b, input logic [8:0] poly);
      byte_t acc;
      byte_t sh;
      acc = '0;
      sh  = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ sh;
         sh = sh[7] ? ({sh[6:0], 1'b0} ^ poly[7:0]) : {sh[6:0], 1'b0};
      end
      return acc;
   endfunction

endpackage

// File: rtl/twofish_rs_keygen_if.sv
// Key-in / S-words-out handshake bundle for twofish_rs_keygen.
// Build option: TWOFISH_KEY256_EN widens the key and adds s2/s3.
interface twofish_rs_keygen_if;
   import twofish_pkg::*;

   logic             key_valid;
   logic             key_ready;
   logic [KEY_W-1:0] key;
   logic             s_valid;
   logic             s_ready;
   logic [31:0]      s0;
   logic [31:0]      s1;
`ifdef TWOFISH_KEY256_EN
   logic [31:0]      s2;
   logic [31:0]      s3;
`endif
   logic             busy;

   modport slave (
      input  key_valid, key, s_ready,
      output key_ready, s_valid, busy, s0, s1
`ifdef TWOFISH_KEY256_EN
      , s2, s3
`endif
   );

   modport master (
      output key_valid, key, s_ready,
      input  key_ready, s_valid, busy, s0, s1
`ifdef TWOFISH_KEY256_EN
      , s2, s3
`endif
   );

endinterface

// File: rtl/twofish_rs_rem.sv
// One RS remainder step: absorb one key byte into a 32-bit remainder modulo g(x).
module twofish_rs_rem
   import twofish_pkg::*;
(
   input  logic [31:0] rem_i,
   input  byte_t       byte_i,
   output logic [31:0] rem_o
);

   byte_t fb;

   assign fb    = rem_i[31:24] ^ byte_i;
   assign rem_o = {rem_i[23:0], 8'h00}
                ^ {gf_mul(fb, RS_GEN[31:24], RS_POLY),
                   gf_mul(fb, RS_GEN[23:16], RS_POLY),
                   gf_mul(fb, RS_GEN[15:8],  RS_POLY),
                   gf_mul(fb, RS_GEN[7:0],   RS_POLY)};

endmodule

// File: rtl/twofish_rs_keygen.sv
// Twofish RS key-schedule: computes the S-words of a key, one byte per word per cycle.
// Build option: TWOFISH_KEY256_EN selects 256-bit keys with four parallel remainder units.
module twofish_rs_keygen
   import twofish_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   twofish_rs_keygen_if.slave bus
);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [31:0]      rem_q    [NUM_WORDS];
   logic [31:0]      rem_d    [NUM_WORDS];
   logic [31:0]      rem_step [NUM_WORDS];
   logic [2:0]       byte_idx;

   // Bytes are absorbed highest index first: m_8i+7 on count 0 down to m_8i on count 7
   assign byte_idx = 3'd7 - cnt_q;

   generate
      for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
         logic [63:0] word_key;
         byte_t       cur_byte;

         assign word_key = key_q[64*gi +: 64];
         assign cur_byte = word_key[{byte_idx, 3'b000} +: 8];

         twofish_rs_rem u_rem (
            .rem_i  (rem_q[gi]),
            .byte_i (cur_byte),
            .rem_o  (rem_step[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         key_q   <= '0;
         for (int w = 0; w < NUM_WORDS; w++) rem_q[w] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         for (int w = 0; w < NUM_WORDS; w++) rem_q[w] <= rem_d[w];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      for (int w = 0; w < NUM_WORDS; w++) rem_d[w] = rem_q[w];

      case (state_q)
         ST_IDLE: begin
            if (bus.key_valid) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               key_d   = bus.key;
               for (int w = 0; w < NUM_WORDS; w++) rem_d[w] = '0;
            end
         end
         ST_RUN: begin
            for (int w = 0; w < NUM_WORDS; w++) rem_d[w] = rem_step[w];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = ST_DONE;
         end
         ST_DONE: begin
            // Remainders are left untouched here so the outputs hold under back-pressure
            if (bus.s_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.key_ready = (state_q == ST_IDLE);
   assign bus.s_valid   = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.s0        = rem_q[0];
   assign bus.s1        = rem_q[1];
`ifdef TWOFISH_KEY256_EN
   assign bus.s2        = rem_q[2];
   assign bus.s3        = rem_q[3];
`endif

endmodule

// File: tb/tb_twofish_rs_keygen.sv
// Directed and random checks of twofish_rs_keygen against hand values and an RS matrix model.
module tb_twofish_rs_keygen;
   import twofish_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   twofish_rs_keygen_if bus_if ();

   twofish_rs_keygen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [7:0] RS_M [0:3][0:7] = '{
      '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
      '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
      '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
      '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Carry-less product followed by reduction modulo x^8+x^6+x^3+x^2+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ ({7'h00, 9'h14D} << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [31:0] rs_word(input logic [63:0] m);
      logic [31:0] s;
      logic [7:0]  acc;
      s = '0;
      for (int r = 0; r < 4; r++) begin
         acc = '0;
         for (int j = 0; j < 8; j++) acc = acc ^ gmul(RS_M[r][j], m[8*j +: 8]);
         s[8*r +: 8] = acc;
      end
      return s;
   endfunction

   function automatic logic [31:0] dut_word(input int w);
      case (w)
         0: return bus_if.s0;
         1: return bus_if.s1;
`ifdef TWOFISH_KEY256_EN
         2: return bus_if.s2;
         3: return bus_if.s3;
`endif
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [KEY_W-1:0] rand_key();
      logic [KEY_W-1:0] r;
      r = '0;
      for (int i = 0; i < KEY_W / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Present a key, then scramble the key bus and count edges until s_valid (bounded)
   task automatic run_key(input logic [KEY_W-1:0] k, output int lat);
      @(negedge clk);
      bus_if.key       = k;
      bus_if.key_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.key_valid = 1'b0;
      bus_if.key       = ~k;
      check_val("busy_after_accept", {31'd0, bus_if.busy}, 32'd1);
      check_val("key_ready_in_run", {31'd0, bus_if.key_ready}, 32'd0);
      lat = 0;
      while (!bus_if.s_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      bus_if.s_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.s_ready = 1'b0;
      check_val("s_valid_after_hs", {31'd0, bus_if.s_valid}, 32'd0);
      check_val("key_ready_after_hs", {31'd0, bus_if.key_ready}, 32'd1);
   endtask

   task automatic directed(input string name, input logic [127:0] k128,
                           input logic [31:0] e0, input logic [31:0] e1);
      int lat;
      run_key(KEY_W'(k128), lat);
      check_val({name, "_lat"}, lat, 32'd8);
      check_val({name, "_s_valid"}, {31'd0, bus_if.s_valid}, 32'd1);
      check_val({name, "_s0"}, bus_if.s0, e0);
      check_val({name, "_s1"}, bus_if.s1, e1);
`ifdef TWOFISH_KEY256_EN
      check_val({name, "_s2"}, bus_if.s2, 32'h0);
      check_val({name, "_s3"}, bus_if.s3, 32'h0);
`endif
      $display("vec %s key=%032h s0=%08h s1=%08h lat=%0d", name, k128, bus_if.s0, bus_if.s1, lat);
      handshake();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [KEY_W-1:0] k;
      int               lat;
      int unsigned      acc_cyc;
      int unsigned      prev_cyc;

      bus_if.key_valid = 1'b0;
      bus_if.key       = '0;
      bus_if.s_ready   = 1'b0;
      prev_cyc         = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_key_ready", {31'd0, bus_if.key_ready}, 32'd1);
      check_val("rst_s_valid", {31'd0, bus_if.s_valid}, 32'd0);
      check_val("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check_val("rst_s0", bus_if.s0, 32'h0);
      check_val("rst_s1", bus_if.s1, 32'h0);
      rst_n = 1'b1;

      directed("zero", 128'h0, 32'h00000000, 32'h00000000);
      directed("m0",   128'h1, 32'hA402A401, 32'h00000000);
      directed("m7",   128'h0100_0000_0000_0000, 32'h0319E59E, 32'h00000000);
      directed("m1",   128'h100, 32'h55A156A4, 32'h00000000);
      directed("m9",   128'h0000_0000_0000_0100_0000_0000_0000_0000, 32'h00000000, 32'h55A156A4);
      directed("m8",   128'h0000_0000_0000_0001_0000_0000_0000_0000, 32'h00000000, 32'hA402A401);
      directed("m15",  128'h0100_0000_0000_0000_0000_0000_0000_0000, 32'h00000000, 32'h0319E59E);
      directed("m0m7", 128'h0100_0000_0000_0001, 32'hA71B419F, 32'h00000000);
      directed("m0x2", 128'h2, 32'h05040502, 32'h00000000);

      // Back-pressure in DONE while the key side keeps changing
      run_key(KEY_W'(128'h1), lat);
      check_val("hold_lat", lat, 32'd8);
      for (int c = 0; c < 20; c++) begin
         bus_if.key_valid = c[0];
         bus_if.key       = rand_key();
         @(posedge clk);
         #1;
         check_val("hold_s_valid", {31'd0, bus_if.s_valid}, 32'd1);
         check_val("hold_key_ready", {31'd0, bus_if.key_ready}, 32'd0);
         check_val("hold_s0", bus_if.s0, 32'hA402A401);
         check_val("hold_s1", bus_if.s1, 32'h0);
      end
      bus_if.key_valid = 1'b0;
      $display("hold 20 cycles s0=%08h", bus_if.s0);
      handshake();

      // Abort mid-run with counter at 4, remainders already non-zero
      @(negedge clk);
      bus_if.key       = KEY_W'(128'h0100_0000_0000_0000_0100_0000_0000_0000);
      bus_if.key_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.key_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("abort_busy_before", {31'd0, bus_if.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("abort_key_ready", {31'd0, bus_if.key_ready}, 32'd1);
      check_val("abort_s_valid", {31'd0, bus_if.s_valid}, 32'd0);
      check_val("abort_busy", {31'd0, bus_if.busy}, 32'd0);
      check_val("abort_s0", bus_if.s0, 32'h0);
      check_val("abort_s1", bus_if.s1, 32'h0);
      $display("abort reset applied at count 4");
      @(negedge clk);
      rst_n = 1'b1;
      directed("after_rst", 128'h100, 32'h55A156A4, 32'h00000000);

      // Random keys back-to-back with s_ready held high
      bus_if.s_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 1000; n++) begin
         k                = rand_key();
         bus_if.key       = k;
         bus_if.key_valid = 1'b1;
         @(posedge clk);
         #1;
         acc_cyc = cyc;
         check_val("rnd_busy", {31'd0, bus_if.busy}, 32'd1);
         if (n > 0) check_val("rnd_period", acc_cyc - prev_cyc, 32'd10);
         prev_cyc   = acc_cyc;
         bus_if.key = rand_key();
         lat = 0;
         while (!bus_if.s_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check_val("rnd_lat", lat, 32'd8);
         for (int w = 0; w < NUM_WORDS; w++) check_val("rnd_word", dut_word(w), rs_word(k[64*w +: 64]));
         $display("rnd %0d key=%h s0=%08h s1=%08h", n, k, bus_if.s0, bus_if.s1);
         @(posedge clk);
         #1;
      end
      bus_if.key_valid = 1'b0;
      bus_if.s_ready   = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/twofish_rs_keygen.md
TWOFISH_RS_KEYGEN -- requirements
Module: twofish_rs_keygen

Interface
REQ-001 Parameter KEY_W, default 128 (256 when TWOFISH_KEY256_EN is defined), is the key width in bits; it is not user-overridable.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_valid  input  1  key presented.
REQ-005 key_ready  output  1  block can accept a key.
REQ-006 key  input  KEY_W  key; byte m_j sits in bits [8j+7:8j].
REQ-007 s_valid  output  1  S-words valid.
REQ-008 s_ready  input  1  consumer accepts the S-words.
REQ-009 s0, s1  output  32 each  S-words from key bytes m0..m7 and m8..m15; byte s_i,0 sits in bits [7:0].
REQ-010 s2, s3  output  32 each  S-words from m16..m23 and m24..m31; present only with TWOFISH_KEY256_EN.
REQ-011 busy  output  1  high in the RUN state.

Function
REQ-012 Each S-word SHALL equal RS·(m_8i..m_8i+7)^T over GF(2^8), field polynomial 0x14D, using the Twofish 4x8 RS matrix.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on key_valid&&key_ready.
- RUN -> DONE after 8 update cycles.
- DONE -> IDLE on s_valid&&s_ready.
REQ-014 key_ready SHALL be high only in IDLE; the key SHALL be registered on acceptance, and key changes afterwards SHALL have no effect.
REQ-015 Each word SHALL use a 32-bit remainder register, cleared on acceptance, that absorbs one byte per RUN cycle, MSB-first, in order m_8i+7 down to m_8i, with the RS remainder step.
REQ-016 All words SHALL be computed in parallel, with a 3-bit counter from 0 to 7; latency is 8 edges from the acceptance edge to s_valid high.
REQ-017 s0..s3 SHALL hold stable while s_valid is high and s_ready is low, for any number of cycles.
REQ-018 In DONE, key_valid SHALL be ignored and key_ready SHALL be low; a new key is accepted no earlier than the cycle after the output handshake.
REQ-019 Outputs SHALL be valid only while s_valid is high; their values outside DONE are don't-care, but deterministic.

Reset
REQ-020 Reset SHALL force state IDLE, counter 0, remainder registers 0, key register 0, key_ready=1, s_valid=0, busy=0 and s0..s3=0.
REQ-021 Reset asserted in RUN or DONE SHALL abort the operation and drop the pending result with no output handshake; after deassertion the block returns to IDLE behaviour on the next edge.

Configuration
REQ-022 With TWOFISH_KEY256_EN defined: KEY_W=256, four remainder units, ports s2 and s3 present, latency unchanged at 8.
REQ-023 Without TWOFISH_KEY256_EN: KEY_W=128, two units, no s2/s3 ports.

Structure
REQ-024 Package twofish_pkg SHALL hold:
- GF polynomial constants 0x14D (RS) and 0x169 (MDS, shared with the S-box/MDS blocks);
- the RS generator coefficients;
- the FSM state enum;
- the byte type.
REQ-025 One combinational sub-module, twofish_rs_rem, SHALL implement the one-byte remainder step (32-bit remainder in, byte in, 32-bit remainder out); it is instantiated once per S-word.

Verification
REQ-026 Key=0, accepted -> after 8 edges s_valid=1, s0=s1=32'h00000000.
REQ-027 Key with m0=01 and all other bytes 0 -> s0=32'hA402A401, s1=0.
REQ-028 Key with m7=01 -> s0=32'h0319E59E; m1=01 -> s0=32'h55A156A4; m9=01 -> s1=32'h55A156A4.
REQ-029 Hold s_ready=0 for 20 cycles in DONE while toggling key_valid and key:
- outputs stable, key_ready=0;
- s_ready=1 -> s_valid falls on the next edge;
- key_ready rises the same edge.
REQ-030 Assert rst_n=0 at counter=4 in RUN -> all outputs reach reset values immediately; after release, a fresh key gives the correct result with no residue.
REQ-031 Random keys (1000), back-to-back with s_ready always 1 -> every word matches the golden RS model; throughput is one key per 10 cycles.
